// File: rtl/msb_pkg.sv
// rtl/msb_pkg.sv - shared constants and helpers for the MSB finder/normalizer slice
package msb_pkg;

    localparam int POS_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic [POS_W-1:0] pos_min(input logic [POS_W-1:0] a,
                                                 input logic [POS_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/msb_normalizer_if.sv
// rtl/msb_normalizer_if.sv - word/position input and normalised result handshake
interface msb_normalizer_if
    import msb_pkg::*;
#(
    parameter int N = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_num;
    logic [POS_W-1:0] in_pos;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_num;
    logic [POS_W-1:0] out_shift;
    logic             out_zero;
    logic             out_err;

    modport master (
        output in_valid, in_num, in_pos, out_ready,
        input  in_ready, out_valid, out_num, out_shift, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_num, in_pos, out_ready,
        output in_ready, out_valid, out_num, out_shift, out_zero, out_err
    );
endinterface

// File: rtl/msb_normalizer.sv
// rtl/msb_normalizer.sv - iterative left-normaliser placing the MSB at bit N-1
module msb_normalizer
    import msb_pkg::*;
#(
    parameter int N    = 32,
    parameter int STEP = 8
) (
    input  logic             clk,
    input  logic             rst,
    msb_normalizer_if.slave  bus
);

    localparam logic [POS_W-1:0] N_POS    = POS_W'(N);
    localparam logic [POS_W-1:0] STEP_POS = POS_W'(STEP);

    logic [1:0]       state;
    logic [N-1:0]     data;
    logic [POS_W-1:0] rem;
    logic [POS_W-1:0] shift_q;
    logic             zero_q;
    logic             err_q;

    logic             in_range;
    logic [POS_W-1:0] pos_m1;
    logic [N-1:0]     num_down;
    logic             above_msb;
    logic [POS_W-1:0] rem_in;
    logic [POS_W-1:0] shift_in;
    logic             err_in;
    logic [POS_W-1:0] step;

    // Consistency check: the claimed MSB bit must be set and nothing above it.
    always_comb begin
        in_range  = (bus.in_pos != '0) && (bus.in_pos <= N_POS);
        pos_m1    = bus.in_pos - 8'd1;
        num_down  = bus.in_num >> pos_m1;
        above_msb = (bus.in_num >> bus.in_pos) != '0;
        rem_in    = in_range ? (N_POS - bus.in_pos) : '0;
        if (bus.in_pos == '0)
            shift_in = N_POS;
        else
            shift_in = rem_in;
        err_in = (bus.in_pos > N_POS)
               | ((bus.in_pos == '0) && (bus.in_num != '0))
               | (in_range && (!num_down[0] || above_msb));
        step = pos_min(STEP_POS, rem);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            data    <= '0;
            rem     <= '0;
            shift_q <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        data    <= bus.in_num;
                        rem     <= rem_in;
                        shift_q <= shift_in;
                        zero_q  <= (bus.in_pos == '0);
                        err_q   <= err_in;
                        state   <= (rem_in != '0) ? ST_SHIFT : ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    data <= data << step;
                    rem  <= rem - step;
                    if (rem <= STEP_POS)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_num   = data;
    assign bus.out_shift = shift_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_err   = err_q;

endmodule

// File: tb/tb_msb_normalizer.sv
// tb/tb_msb_normalizer.sv - directed self-checking bench for msb_normalizer
module tb_msb_normalizer;
    import msb_pkg::*;

    localparam int N    = 32;
    localparam int STEP = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    msb_normalizer_if #(.N(N)) bus ();

    msb_normalizer #(.N(N), .STEP(STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, ".out_num"},   64'(bus.out_num),   64'd0);
        check({tag, ".out_shift"}, 64'(bus.out_shift), 64'd0);
        check({tag, ".out_zero"},  64'(bus.out_zero),  64'd0);
        check({tag, ".out_err"},   64'(bus.out_err),   64'd0);
        check({tag, ".in_ready"},  64'(bus.in_ready),  64'd1);
    endtask

    // Accepts one word and checks latency and the held result; hold_cycles of
    // backpressure are applied before out_ready is raised.
    task automatic run(input string tag, input logic [N-1:0] num, input logic [7:0] pos,
                       input logic [N-1:0] e_num, input logic [7:0] e_shift,
                       input logic e_zero, input logic e_err, input int e_lat,
                       input int hold_cycles);
        int lat;
        bus.in_valid  = 1'b1;
        bus.in_num    = num;
        bus.in_pos    = pos;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        bus.in_num   = '0;
        bus.in_pos   = '0;
        check({tag, ".in_ready_busy"}, 64'(bus.in_ready), 64'd0);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check({tag, ".latency"},   64'(lat),           64'(e_lat));
        check({tag, ".out_num"},   64'(bus.out_num),   64'(e_num));
        check({tag, ".out_shift"}, 64'(bus.out_shift), 64'(e_shift));
        check({tag, ".out_zero"},  64'(bus.out_zero),  64'(e_zero));
        check({tag, ".out_err"},   64'(bus.out_err),   64'(e_err));
        for (int i = 0; i < hold_cycles; i++) begin
            tick();
            check({tag, ".hold_valid"},  64'(bus.out_valid), 64'd1);
            check({tag, ".hold_num"},    64'(bus.out_num),   64'(e_num));
            check({tag, ".hold_shift"},  64'(bus.out_shift), 64'(e_shift));
            check({tag, ".hold_ready"},  64'(bus.in_ready),  64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, ".valid_drop"}, 64'(bus.out_valid), 64'd0);
        check({tag, ".ready_back"}, 64'(bus.in_ready),  64'd1);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_num    = '0;
        bus.in_pos    = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check_idle_zero("reset");
        rst = 1'b0;

        run("minpos",   32'h0000_0001, 8'd1,  32'h8000_0000, 8'd31, 1'b0, 1'b0, 4, 0);
        run("normed",   32'h8000_0000, 8'd32, 32'h8000_0000, 8'd0,  1'b0, 1'b0, 0, 0);
        run("zero",     32'h0000_0000, 8'd0,  32'h0000_0000, 8'd32, 1'b1, 1'b0, 0, 0);
        run("zero_err", 32'h0000_0010, 8'd0,  32'h0000_0010, 8'd32, 1'b1, 1'b1, 0, 0);
        run("bad_pos",  32'h0000_00F0, 8'd4,  32'h0000_0000, 8'd28, 1'b0, 1'b1, 4, 0);
        run("above",    32'h0000_0030, 8'd5,  32'h8000_0000, 8'd27, 1'b0, 1'b1, 4, 0);
        run("pos_big",  32'h0000_0005, 8'd40, 32'h0000_0005, 8'd0,  1'b0, 1'b1, 0, 0);
        run("rem_step", 32'h0080_0000, 8'd24, 32'h8000_0000, 8'd8,  1'b0, 1'b0, 1, 0);
        run("rem_9",    32'h0040_0000, 8'd23, 32'h8000_0000, 8'd9,  1'b0, 1'b0, 2, 0);
        run("bpress",   32'h0001_2345, 8'd17, 32'h91A2_8000, 8'd15, 1'b0, 1'b0, 2, 3);

        // Reset lands in the second SHIFT cycle of the minimum-position case.
        bus.in_valid = 1'b1;
        bus.in_num   = 32'h0000_0001;
        bus.in_pos   = 8'd1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_zero("midrst");
        run("after_rst", 32'h0000_0001, 8'd1, 32'h8000_0000, 8'd31, 1'b0, 1'b0, 4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
